// File: rtl/rf_arb_pkg.sv
// Shared types and widths for the register-file read arbiter.
// The lock feature (ARB/LOCKED FSM) is built only with RF_ARB_LOCK_EN defined.
package rf_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int IDX_W  = 5;
  localparam int DATA_W = 32;
  localparam int RID_W  = 3;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin winner search: the first requester at or after ptr
// wins, wrapping modulo NUM_REQ, and is reported as a one-hot grant.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [2*NUM_REQ-1:0] req_shift;
  logic [NUM_REQ-1:0]   req_rot;
  logic [NUM_REQ-1:0]   pick_rot;
  logic [2*NUM_REQ-1:0] pick_dbl;

  // Rotating a doubled copy puts requester ptr at bit 0, so the search is a
  // plain lowest-set-bit pick; rotating back and folding restores positions.
  assign req_dbl   = {req, req};
  assign req_shift = req_dbl >> ptr;
  assign req_rot   = req_shift[NUM_REQ-1:0];
  assign pick_rot  = req_rot & (~req_rot + 1'b1);
  assign pick_dbl  = {{NUM_REQ{1'b0}}, pick_rot} << ptr;
  assign gnt       = pick_dbl[NUM_REQ-1:0] | pick_dbl[2*NUM_REQ-1:NUM_REQ];

endmodule

// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter sharing one 32:1 register read mux among NUM_REQ readers,
// with a one-cycle registered response. Optional port locking: RF_ARB_LOCK_EN.
module rf_read_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_LOCK = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*IDX_W-1:0] addr,
  input  logic [NUM_REQ-1:0]       lock,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [IDX_W-1:0]         rf_sel,
  input  logic [DATA_W-1:0]        rf_data,
  output logic                     rvalid,
  output logic [RID_W-1:0]         rid,
  output logic [DATA_W-1:0]        rdata
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   ptr_reg, ptr_next;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [PTR_W-1:0]   arb_idx;
  logic [PTR_W-1:0]   ptr_after;
  logic [NUM_REQ-1:0] gnt_int;
  logic [PTR_W-1:0]   win_idx;
  logic [IDX_W-1:0]   sel_reg;
  logic               any_gnt;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req (req),
    .ptr (ptr_reg),
    .gnt (arb_gnt)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) arb_idx = PTR_W'(i);
    end
  end

  assign ptr_after = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;

`ifdef RF_ARB_LOCK_EN
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  arb_state_t       state_reg, state_next;
  logic [PTR_W-1:0] owner_reg, owner_next;
  logic [CNT_W-1:0] lock_cnt_reg, lock_cnt_next;
  logic             hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ARB;
      owner_reg    <= '0;
      lock_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      lock_cnt_reg <= lock_cnt_next;
    end
  end

  // The pointer already sits at owner+1 from the locking grant, so the exit
  // cycle simply arbitrates normally from it.
  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    lock_cnt_next = lock_cnt_reg;
    ptr_next      = ptr_reg;
    gnt_int       = '0;
    win_idx       = arb_idx;
    hold = (state_reg == LOCKED) && req[owner_reg] && lock[owner_reg] &&
           (lock_cnt_reg < CNT_W'(MAX_LOCK));
    if (hold) begin
      gnt_int[owner_reg] = 1'b1;
      win_idx            = owner_reg;
      lock_cnt_next      = lock_cnt_reg + 1'b1;
    end else begin
      state_next    = ARB;
      lock_cnt_next = '0;
      gnt_int       = arb_gnt;
      if (|arb_gnt) begin
        ptr_next = ptr_after;
        if (lock[arb_idx]) begin
          state_next    = LOCKED;
          owner_next    = arb_idx;
          lock_cnt_next = CNT_W'(1);
        end
      end
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = (^lock) | (MAX_LOCK == 0);

  always_comb begin
    gnt_int  = arb_gnt;
    win_idx  = arb_idx;
    ptr_next = ptr_reg;
    if (|arb_gnt) ptr_next = ptr_after;
  end
`endif

  assign gnt     = rst_n ? gnt_int : '0;
  assign any_gnt = |gnt;

  always_comb begin
    rf_sel = sel_reg;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) rf_sel = addr[i*IDX_W +: IDX_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
      sel_reg <= '0;
      rvalid  <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
    end else begin
      ptr_reg <= ptr_next;
      rvalid  <= any_gnt;
      if (any_gnt) begin
        sel_reg <= rf_sel;
        rid     <= RID_W'(win_idx);
        rdata   <= rf_data;
      end
    end
  end

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Directed bench for rf_read_arbiter (NUM_REQ=4, MAX_LOCK=8); the lock
// scenario is exercised when RF_ARB_LOCK_EN is defined.
module tb_rf_read_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N*5-1:0] addr;
  logic [N-1:0]  lock;
  logic [N-1:0]  gnt;
  logic [4:0]    rf_sel;
  logic [31:0]   rf_data;
  logic          rvalid;
  logic [2:0]    rid;
  logic [31:0]   rdata;

  logic [31:0] regfile [32];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rf_data = regfile[rf_sel];

  rf_read_arbiter #(.NUM_REQ(N), .MAX_LOCK(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .addr    (addr),
    .lock    (lock),
    .gnt     (gnt),
    .rf_sel  (rf_sel),
    .rf_data (rf_data),
    .rvalid  (rvalid),
    .rid     (rid),
    .rdata   (rdata)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    lock  = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    lock  = '0;
    addr  = {5'd4, 5'd3, 5'd2, 5'd1};
    @(negedge clk);
    @(negedge clk);
    checks++; if (gnt !== 4'b0000) $display("FAIL reset_gnt got %b exp %b", gnt, 4'b0000);
    else $display("reset_gnt ok %b", gnt);
    if (gnt !== 4'b0000) errors++;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", rvalid); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    checks++; if (rid !== 3'd0) begin errors++; $display("FAIL reset_rid got %0d exp 0", rid); end
    checks++; if (rf_sel !== 5'd0) begin errors++; $display("FAIL reset_rf_sel got %0d exp 0", rf_sel); end
  endtask

  task automatic test_single_read();
    rst_n = 1'b1;
    req   = 4'b0100;
    addr[10 +: 5] = 5'd7;
    #1;
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b exp 0100", gnt); end
    checks++; if (rf_sel !== 5'd7) begin errors++; $display("FAIL single_rf_sel got %0d exp 7", rf_sel); end
    $display("single read: gnt=%b rf_sel=%0d", gnt, rf_sel);
    step();
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL single_rvalid got %b exp 1", rvalid); end
    checks++; if (rid !== 3'd2) begin errors++; $display("FAIL single_rid got %0d exp 2", rid); end
    checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rdata got %h exp deadbeef", rdata); end
    $display("single response: rvalid=%b rid=%0d rdata=%h", rvalid, rid, rdata);
    req = '0;
    step();
    #1;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL idle_rvalid got %b exp 0", rvalid); end
    checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL idle_rdata_hold got %h exp deadbeef", rdata); end
    checks++; if (rid !== 3'd2) begin errors++; $display("FAIL idle_rid_hold got %0d exp 2", rid); end
    checks++; if (rf_sel !== 5'd7) begin errors++; $display("FAIL idle_rf_sel_hold got %0d exp 7", rf_sel); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL idle_gnt got %b exp 0000", gnt); end
    $display("idle: rvalid=%b rf_sel=%0d", rvalid, rf_sel);
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_g;
    int prev;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < N; i++) addr[i*5 +: 5] = 5'(8 + i);
    for (int c = 0; c < 8; c++) begin
      #1;
      exp_g = N'(1 << (c % N));
      checks++; if (gnt !== exp_g) begin errors++; $display("FAIL fair_gnt c%0d got %b exp %b", c, gnt, exp_g); end
      checks++; if (rf_sel !== 5'(8 + c % N)) begin errors++; $display("FAIL fair_rf_sel c%0d got %0d exp %0d", c, rf_sel, 8 + c % N); end
      checks++; if (rvalid !== (c != 0)) begin errors++; $display("FAIL fair_rvalid c%0d got %b exp %b", c, rvalid, c != 0); end
      if (c > 0) begin
        prev = (c - 1) % N;
        checks++; if (rid !== 3'(prev)) begin errors++; $display("FAIL fair_rid c%0d got %0d exp %0d", c, rid, prev); end
        checks++; if (rdata !== regfile[8 + prev]) begin errors++; $display("FAIL fair_rdata c%0d got %h exp %h", c, rdata, regfile[8 + prev]); end
      end
      $display("fairness cycle %0d: gnt=%b rvalid=%b rid=%0d", c, gnt, rvalid, rid);
      step();
    end
    checks++; if (rvalid !== 1'b1 || rid !== 3'd3) begin errors++; $display("FAIL fair_last got rvalid=%b rid=%0d exp rvalid=1 rid=3", rvalid, rid); end
    req = '0;
    step();
  endtask

  task automatic test_back_to_back();
    req = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      addr[5 +: 5] = 5'(16 + c);
      #1;
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL b2b_gnt c%0d got %b exp 0010", c, gnt); end
      if (c > 0) begin
        checks++; if (rvalid !== 1'b1 || rdata !== regfile[16 + c - 1]) begin
          errors++; $display("FAIL b2b_resp c%0d got rvalid=%b rdata=%h exp 1 %h", c, rvalid, rdata, regfile[16 + c - 1]);
        end
      end
      $display("back-to-back cycle %0d: gnt=%b rvalid=%b rdata=%h", c, gnt, rvalid, rdata);
      step();
    end
    checks++; if (rvalid !== 1'b1 || rdata !== regfile[19]) begin errors++; $display("FAIL b2b_last got rvalid=%b rdata=%h exp 1 %h", rvalid, rdata, regfile[19]); end
    req = '0;
    step();
  endtask

  task automatic test_reset_mid();
    req = 4'b0010;
    addr[5 +: 5] = 5'd20;
    #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL mid_gnt got %b exp 0010", gnt); end
    @(posedge clk);
    #1;
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL mid_rvalid_pre got %b exp 1", rvalid); end
    rst_n = 1'b0;
    req   = 4'b1111;
    #1;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid_in_reset got %b exp 0", rvalid); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid_release got %b exp 0", rvalid); end
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_first_gnt got %b exp 0001", gnt); end
    $display("reset mid-stream: release gnt=%b rvalid=%b", gnt, rvalid);
    req = 4'b0001;
    step();
    checks++; if (rvalid !== 1'b1 || rid !== 3'd0) begin errors++; $display("FAIL mid_post_resp got rvalid=%b rid=%0d exp 1 0", rvalid, rid); end
    req = '0;
    step();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL mid_post_idle got %b exp 0", rvalid); end
  endtask

`ifdef RF_ARB_LOCK_EN
  task automatic test_lock();
    logic [N-1:0] exp_g;
    do_reset();
    req  = 4'b0011;
    lock = 4'b0010;
    addr[0 +: 5] = 5'd3;
    addr[5 +: 5] = 5'd4;
    for (int c = 0; c < 10; c++) begin
      #1;
      exp_g = (c >= 1 && c <= 8) ? 4'b0010 : 4'b0001;
      checks++; if (gnt !== exp_g) begin errors++; $display("FAIL lock_gnt c%0d got %b exp %b", c, gnt, exp_g); end
      $display("lock cycle %0d: gnt=%b", c, gnt);
      step();
    end
    req  = '0;
    lock = '0;
    step();
  endtask
`else
  task automatic test_lock_ignored();
    logic [N-1:0] exp_g;
    // ptr is 1 here: the last grant went to requester 0
    req  = 4'b0011;
    lock = 4'b0011;
    for (int c = 0; c < 4; c++) begin
      #1;
      exp_g = (c % 2 == 0) ? 4'b0010 : 4'b0001;
      checks++; if (gnt !== exp_g) begin errors++; $display("FAIL nolock_gnt c%0d got %b exp %b", c, gnt, exp_g); end
      $display("lock ignored cycle %0d: gnt=%b", c, gnt);
      step();
    end
    req  = '0;
    lock = '0;
    step();
  endtask
`endif

  initial begin
    for (int i = 0; i < 32; i++) regfile[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
    regfile[7] = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    req   = '0;
    lock  = '0;
    addr  = '0;
    test_reset();
    test_single_read();
    test_fairness();
    test_back_to_back();
    test_reset_mid();
`ifdef RF_ARB_LOCK_EN
    test_lock();
`else
    test_lock_ignored();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
